load_cell_sched: RTL and testbench
==================================

# load_cell_sched

Round-robin conversion scheduler for the external A2D converter. It feeds the steering-enable and balance logic by sequencing SPI transactions over four channels: left load cell, right load cell, steering pot and battery. It sits between the SPI master and the consumers of `lft_ld`, `rght_ld`, `steer_pot` and `batt`, and holds the most recent 12-bit result per channel in registers.

## Interface
Parameters:
- `LFT_CH`, default 3'd0, A2D channel number for the left load cell.
- `RGHT_CH`, default 3'd4, A2D channel number for the right load cell.
- `STEER_CH`, default 3'd5, A2D channel number for the steering pot.
- `BATT_CH`, default 3'd6, A2D channel number for the battery.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `nxt` in 1: request to start the next conversion; one-cycle pulse.
- `wrt` out 1: one-cycle strobe that starts an SPI transaction.
- `cmd` out 16: SPI command word, equal to {2'b00, ch[2:0], 11'h000}.
- `done` in 1: one-cycle pulse from the SPI master when a transaction completes.
- `rd_data` in 16: SPI response word; bits [11:0] carry the result.
- `lft_ld`, `rght_ld`, `steer_pot`, `batt` out 12 each: latest result for each channel.
- `cnv_cmplt` out 1: one-cycle pulse when a channel register has been updated.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Round-robin pointer `rr` (2 bits) follows the sequence 0→LFT, 1→RGHT, 2→STEER, 3→BATT, then wraps 3→0.
- The channel field of `cmd` is driven from `rr` combinationally. `cmd` holds the same value for both transactions of a conversion.
- States:
  - IDLE: on `nxt`, assert `wrt` and go to CMD. Otherwise stay.
  - CMD: wait for `done`; on `done` go to GAP.
  - GAP: one dead cycle, required by the A2D between transactions. Then assert `wrt` and go to READ.
  - READ: wait for `done`. On `done`, load `rd_data[11:0]` into the register selected by `rr`, pulse `cnv_cmplt`, increment `rr`, and go to IDLE.
- A `nxt` pulse arriving in any state other than IDLE is dropped, not queued.
- A `done` pulse in IDLE or GAP is ignored.
- Unused state encodings go to IDLE.
- Only the selected channel register is written; the other three hold their values.
- `rd_data[15:12]` is ignored.

## Timing
- Reset values: `rr`=0, state=IDLE, all four channel registers 12'h000, `wrt`=0, `cnv_cmplt`=0, `busy`=0.
- `wrt` is registered. It rises in the cycle after `nxt` is sampled in IDLE, and in the cycle after GAP.
- Minimum spacing from `nxt` to `cnv_cmplt` is the SPI latency × 2 plus 3 cycles.
- Channel registers and `cnv_cmplt` update on the same clock edge, in the cycle after `done` is sampled in READ.
- `nxt` coinciding with the final `done` in READ is dropped, because the state is not IDLE.
- `nxt` in the first IDLE cycle after READ is accepted and uses the incremented `rr`.
- Reset asserted mid-transaction returns everything to reset values immediately. A later stray `done` from the SPI master is then ignored (IDLE).
- `wrt` is never high for two consecutive cycles.

## Structure
- Shared package `segway_pkg` holds:
  - `a2d_state_t` enum: IDLE, CMD, GAP, READ.
  - `a2d_chan_t` enum for the four logical channels.
  - Localparam for the command prefix, 2'b00.
- Sub-module `a2d_chan_sel`:
  - Contains the `rr` counter and the channel-number mux.
  - Inputs: `clk`, `rst_n`, `adv`. Outputs: `rr`, `ch[2:0]`.
- The FSM and the result registers stay in the top module.

## Test plan
- Reset, then `nxt` with an SPI model returning 16'hF123:
  - `cmd`=16'h0000 on both `wrt` strobes.
  - `lft_ld`=12'h123; the other three registers stay 12'h000.
  - One `cnv_cmplt` pulse.
- Four back-to-back conversions returning 12'h111, 12'h222, 12'h333, 12'h444:
  - Results land in `lft_ld`, `rght_ld`, `steer_pot`, `batt` in that order.
  - `cmd` channel fields are 0, 4, 5, 6.
  - A fifth conversion returns to channel 0.
- `nxt` pulsed in CMD, GAP and READ: no extra `wrt` strobes and no change in the sequence.
- `done` injected in IDLE and in GAP: no state change and no register write.
- `rst_n` dropped in READ after loading 12'hABC on `rght_ld`:
  - All outputs return to 0.
  - The next conversion targets channel 0.
- GAP check: between the first `done` and the second `wrt`, exactly one cycle passes with `wrt` low.

Source files
------------

// File: rtl/segway_pkg.sv
// Shared types and constants for the segway A2D conversion path.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GAP,
        READ
    } a2d_state_t;

    // Logical channels in round-robin order
    typedef enum logic [1:0] {
        CH_LFT,
        CH_RGHT,
        CH_STEER,
        CH_BATT
    } a2d_chan_t;

    localparam logic [1:0] CMD_PREFIX = 2'b00;

    function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
        return {CMD_PREFIX, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_chan_sel.sv
// Round-robin pointer over the four logical channels and the mapping
// from logical channel to physical A2D channel number.
module a2d_chan_sel
    import segway_pkg::*;
#(
    parameter logic [2:0] LFT_CH   = 3'd0,
    parameter logic [2:0] RGHT_CH  = 3'd4,
    parameter logic [2:0] STEER_CH = 3'd5,
    parameter logic [2:0] BATT_CH  = 3'd6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    output logic [1:0] rr,
    output logic [2:0] ch
);

    logic [1:0] rr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 2'd0;
        end else if (adv) begin
            rr_q <= rr_q + 2'd1;
        end
    end

    assign rr = rr_q;

    always_comb begin
        ch = LFT_CH;
        unique case (a2d_chan_t'(rr_q))
            CH_LFT:   ch = LFT_CH;
            CH_RGHT:  ch = RGHT_CH;
            CH_STEER: ch = STEER_CH;
            CH_BATT:  ch = BATT_CH;
        endcase
    end

endmodule

// File: rtl/load_cell_sched.sv
// Round-robin A2D conversion scheduler: two SPI transactions per conversion
// (command, then read-back) with one dead cycle between them.
module load_cell_sched
    import segway_pkg::*;
#(
    parameter logic [2:0] LFT_CH   = 3'd0,
    parameter logic [2:0] RGHT_CH  = 3'd4,
    parameter logic [2:0] STEER_CH = 3'd5,
    parameter logic [2:0] BATT_CH  = 3'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy
);

    a2d_state_t  state_q, state_d;
    logic        wrt_q, wrt_d;
    logic        cnv_q, cnv_d;
    logic        ld;
    logic        adv;
    logic [1:0]  rr;
    logic [2:0]  ch;
    logic [11:0] lft_q, rght_q, steer_q, batt_q;

    // The A2D status nibble is not used by any consumer
    logic [3:0]  unused_rd_hi;
    assign unused_rd_hi = rd_data[15:12];

    a2d_chan_sel #(
        .LFT_CH   (LFT_CH),
        .RGHT_CH  (RGHT_CH),
        .STEER_CH (STEER_CH),
        .BATT_CH  (BATT_CH)
    ) u_chan_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv),
        .rr    (rr),
        .ch    (ch)
    );

    always_comb begin
        state_d = state_q;
        wrt_d   = 1'b0;
        cnv_d   = 1'b0;
        ld      = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (nxt) begin
                    wrt_d   = 1'b1;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                wrt_d   = 1'b1;
                state_d = READ;
            end
            READ: begin
                if (done) begin
                    ld      = 1'b1;
                    cnv_d   = 1'b1;
                    adv     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wrt_q   <= 1'b0;
            cnv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wrt_q   <= wrt_d;
            cnv_q   <= cnv_d;
        end
    end

    // Only the register addressed by the current pointer is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            steer_q <= 12'h000;
            batt_q  <= 12'h000;
        end else if (ld) begin
            unique case (a2d_chan_t'(rr))
                CH_LFT:   lft_q   <= rd_data[11:0];
                CH_RGHT:  rght_q  <= rd_data[11:0];
                CH_STEER: steer_q <= rd_data[11:0];
                CH_BATT:  batt_q  <= rd_data[11:0];
            endcase
        end
    end

    assign wrt       = wrt_q;
    assign cmd       = a2d_cmd(ch);
    assign cnv_cmplt = cnv_q;
    assign busy      = (state_q != IDLE);
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign steer_pot = steer_q;
    assign batt      = batt_q;

endmodule

// File: tb/tb_load_cell_sched.sv
// Randomized scoreboard bench for load_cell_sched with an inline SPI responder.
module tb_load_cell_sched;

    typedef logic [3:0][11:0] regs_t;

    localparam int M_NXT_CMD  = 1;
    localparam int M_NXT_GAP  = 2;
    localparam int M_NXT_READ = 4;
    localparam int M_DONE_GAP = 8;
    localparam int M_NXT_LAST = 16;
    localparam int M_RST_READ = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        cnv_cmplt;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Reference model: logical pointer, physical channel table, register image
    logic [2:0]  ch_tab [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
    int          m_rr;
    regs_t       m_regs;
    logic [15:0] cmd_q [$];
    regs_t       res_q [$];

    load_cell_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .wrt       (wrt),
        .cmd       (cmd),
        .done      (done),
        .rd_data   (rd_data),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] pack_regs(input regs_t r);
        return {r[0], r[1], r[2], r[3]};
    endfunction

    task automatic step();
        @(negedge clk);
        nxt  = 1'b0;
        done = 1'b0;
    endtask

    task automatic model_reset();
        m_rr   = 0;
        m_regs = '0;
        cmd_q.delete();
        res_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_regs"}, {lft_ld, rght_ld, steer_pot, batt}, 48'h0);
        check({tag, "_ctl"}, {45'h0, wrt, cnv_cmplt, busy}, 48'h0);
        check({tag, "_cmd"}, {32'h0, cmd}, 48'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all_zero("reset");
        step();
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    // Wait (bounded) for a wrt strobe, sampling at the falling edge
    task automatic wait_wrt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (wrt === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        check("wrt_timeout", 48'd0, 48'd1);
    endtask

    // One conversion. Called at a falling edge with the DUT known to be idle.
    task automatic do_conv(input int mode, input logic [15:0] data);
        bit ok;
        int lat;
        int gap;
        nxt = 1'b1;
        cmd_q.push_back({2'b00, ch_tab[m_rr], 11'h000});
        cmd_q.push_back({2'b00, ch_tab[m_rr], 11'h000});
        m_regs[m_rr] = data[11:0];
        res_q.push_back(m_regs);
        m_rr = (m_rr + 1) % 4;
        wait_wrt(ok);
        if (!ok) return;
        // Command transaction
        if ((mode & M_NXT_CMD) != 0) nxt = 1'b1;
        lat = $urandom_range(1, 4);
        repeat (lat - 1) step();
        done    = 1'b1;
        rd_data = 16'($urandom);
        step();
        // Dead cycle
        if ((mode & M_DONE_GAP) != 0) done = 1'b1;
        if ((mode & M_NXT_GAP) != 0) nxt = 1'b1;
        gap = 0;
        for (int i = 0; i < 8 && wrt !== 1'b1; i++) begin
            gap++;
            step();
        end
        check("gap_cycles", 48'(gap), 48'd1);
        if (wrt !== 1'b1) return;
        // Read transaction
        if ((mode & M_NXT_READ) != 0) nxt = 1'b1;
        if ((mode & M_RST_READ) != 0) begin
            step();
            check("busy_in_read", {47'h0, busy}, 48'd1);
            #2 rst_n = 1'b0;
            model_reset();
            #1 check_all_zero("midreset");
            step();
            #2 rst_n = 1'b1;
            step();
            done = 1'b1;
            step();
            check("stray_done_busy", {47'h0, busy}, 48'd0);
            check("stray_done_regs", {lft_ld, rght_ld, steer_pot, batt}, 48'h0);
            return;
        end
        lat = $urandom_range(1, 4);
        repeat (lat - 1) step();
        done    = 1'b1;
        rd_data = data;
        if ((mode & M_NXT_LAST) != 0) nxt = 1'b1;
        step();
        check("cnv_pulse", {46'h0, cnv_cmplt, busy}, 48'b10);
    endtask

    // Monitor: compares every wrt strobe and every completion against the queues
    initial begin
        logic  prev_wrt;
        regs_t exp;
        prev_wrt = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wrt = 1'b0;
            end else begin
                if (wrt === 1'b1) begin
                    if (prev_wrt) check("wrt_back_to_back", 48'd1, 48'd0);
                    if (cmd_q.size() == 0) begin
                        check("unexpected_wrt", 48'd1, 48'd0);
                    end else begin
                        check("cmd_word", {32'h0, cmd}, {32'h0, cmd_q.pop_front()});
                    end
                end
                if (cnv_cmplt === 1'b1) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_cnv_cmplt", 48'd1, 48'd0);
                    end else begin
                        exp = res_q.pop_front();
                        check("result_regs", {lft_ld, rght_ld, steer_pot, batt}, pack_regs(exp));
                    end
                end
                prev_wrt = (wrt === 1'b1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        model_reset();
        do_reset();

        // Single conversion with a dirty status nibble
        do_conv(0, 16'hF123);
        check("first_lft", {36'h0, lft_ld}, 48'h123);
        check("first_others", {12'h0, rght_ld, steer_pot, batt}, 48'h0);

        // Four back-to-back conversions and a wrap to channel 0
        do_reset();
        do_conv(0, 16'h0111);
        do_conv(0, 16'h0222);
        do_conv(0, 16'h0333);
        do_conv(0, 16'h0444);
        do_conv(0, 16'h0555);

        // Dropped nxt pulses in every busy state, stray done in GAP and IDLE
        do_conv(M_NXT_CMD | M_NXT_GAP | M_NXT_READ | M_NXT_LAST, 16'h0AAA);
        do_conv(M_DONE_GAP, 16'h0BBB);
        step();
        done = 1'b1;
        step();
        check("idle_done_busy", {47'h0, busy}, 48'd0);
        check("idle_done_regs", {lft_ld, rght_ld, steer_pot, batt}, pack_regs(m_regs));

        // Randomized mix
        for (int n = 0; n < 24; n++) begin
            mode = int'($urandom_range(0, 31));
            do_conv(mode, 16'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) step();
                if ($urandom_range(0, 1) == 1) done = 1'b1;
                step();
            end
        end

        // Reset in READ after the right cell holds 12'hABC
        do_reset();
        do_conv(0, 16'h0321);
        do_conv(0, 16'h0ABC);
        check("rght_abc", {36'h0, rght_ld}, 48'hABC);
        do_conv(M_RST_READ, 16'h0777);
        do_conv(0, 16'h0456);
        check("after_reset_lft", {lft_ld, rght_ld, steer_pot, batt}, {12'h456, 36'h0});

        repeat (4) step();
        check("queues_drained", 48'(cmd_q.size() + res_q.size()), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
